// File: rtl/pll_lock_supervisor.sv
// Consumer-side rPLL supervisor: sequences the PLL reset, qualifies lock and
// releases a registered system reset, with retries and a sticky fault.
module pll_lock_supervisor #(
  parameter int PLL_RST_CYCLES     = 27,
  parameter int LOCK_STABLE_CYCLES = 2700,
  parameter int LOSS_FILTER        = 4,
  parameter int RETRY_TIMEOUT      = 270000,
  parameter int MAX_RETRIES        = 3
) (
  input  logic       clkin,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       relock_req,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       fault,
  output logic [3:0] retry_cnt
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_P = max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                              max2(LOSS_FILTER, RETRY_TIMEOUT));
  localparam int CNT_W = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
  localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(RETRY_TIMEOUT - 1);
  localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    RESET_PLL,
    WAIT_LOCK,
    STABILIZE,
    RUN,
    FAULT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             lock_meta;
  logic             lock_s;
  logic [3:0]       retry_inc;

  assign retry_inc = (retry_cnt == 4'd15) ? 4'd15 : retry_cnt + 4'd1;

  // Outputs are written on the same edge that changes state, so they are
  // always a registered decode of the state being entered.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RESET_PLL;
      cnt       <= '0;
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
      pll_reset <= 1'b1;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      fault     <= 1'b0;
      retry_cnt <= 4'd0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
      case (state)
        RESET_PLL: begin
          if (cnt == RST_LAST) begin
            state     <= WAIT_LOCK;
            cnt       <= '0;
            pll_reset <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT_LOCK: begin
          if (lock_s) begin
            state <= STABILIZE;
            cnt   <= '0;
          end else if (cnt == TMO_LAST) begin
            cnt       <= '0;
            retry_cnt <= retry_inc;
            if (retry_inc == RETRY_LIMIT) begin
              state <= FAULT;
              fault <= 1'b1;
            end else begin
              state     <= RESET_PLL;
              pll_reset <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STABILIZE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state     <= RUN;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            sys_rst_n <= 1'b1;
            locked    <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          // An explicit request wins over the loss filter in the same cycle.
          if (relock_req || (!lock_s && cnt == LOSS_LAST)) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            pll_reset <= 1'b1;
            sys_rst_n <= 1'b0;
            locked    <= 1'b0;
          end else if (lock_s) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        FAULT: begin
          if (relock_req) begin
            state     <= RESET_PLL;
            cnt       <= '0;
            retry_cnt <= 4'd0;
            pll_reset <= 1'b1;
            fault     <= 1'b0;
          end
        end
        default: begin
          state     <= RESET_PLL;
          cnt       <= '0;
          pll_reset <= 1'b1;
          sys_rst_n <= 1'b0;
          locked    <= 1'b0;
          fault     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the on-chip rPLL from the consumer side. Drives the PLL's `reset` input, watches its asynchronous `lock` output and releases a clean, registered system reset only after lock has held stable. Re-sequences the PLL on loss of lock, on a lock timeout or on request, with bounded retries and a sticky fault. Runs on the 27 MHz reference clock that also feeds the PLL's `clkin`, so it never depends on the clock it supervises.

## Interface
- PLL_RST_CYCLES, 27: cycles `pll_reset` is held high per attempt (1 µs). Must be ≥1.
- LOCK_STABLE_CYCLES, 2700: consecutive synchronized-lock-high cycles required before release (100 µs).
- LOSS_FILTER, 4: consecutive synchronized-lock-low cycles in RUN that count as loss of lock.
- RETRY_TIMEOUT, 270000: maximum WAIT_LOCK cycles per attempt (10 ms).
- MAX_RETRIES, 3: failed attempts before FAULT. Range 1..15.

Ports:
- clkin  in  1  27 MHz reference clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- pll_lock  in  1  PLL `lock`; asynchronous to clkin.
- relock_req  in  1  single-cycle request to re-sequence the PLL; honoured in RUN and FAULT only.
- pll_reset  out  1  to the PLL `reset`; active-high.
- sys_rst_n  out  1  active-low reset for logic clocked by the PLL outputs; the consumer resynchronizes it.
- locked  out  1  high while in RUN.
- fault  out  1  high while in FAULT.
- retry_cnt  out  4  failed attempts since the last successful release; saturates at 15.

## Operation
- `pll_lock` passes through a 2-flop synchronizer; `lock_s` is the second flop. All FSM decisions use `lock_s`.
- One shared counter `cnt` (width $clog2 of the largest parameter + 1). It clears on every state entry.
- States and transitions:
  - RESET_PLL: `pll_reset`=1, `sys_rst_n`=0. When `cnt` = PLL_RST_CYCLES−1, go to WAIT_LOCK.
  - WAIT_LOCK: `pll_reset`=0.
    - If `lock_s`=1, go to STABILIZE.
    - Otherwise, when `cnt` = RETRY_TIMEOUT−1, increment `retry_cnt`. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
    - Lock has priority over timeout in the same cycle.
  - STABILIZE: `cnt` counts while `lock_s`=1.
    - If `lock_s`=0, return to WAIT_LOCK. The timeout restarts; no retry is charged.
    - When `cnt` = LOCK_STABLE_CYCLES−1 with `lock_s`=1, go to RUN and clear `retry_cnt`.
  - RUN: `sys_rst_n`=1, `locked`=1. `cnt` counts consecutive `lock_s`=0 cycles and clears on any `lock_s`=1.
    - When `cnt` reaches LOSS_FILTER−1 with `lock_s`=0, go to RESET_PLL.
    - `relock_req`=1 also goes to RESET_PLL; it takes priority over loss detection.
  - FAULT: `pll_reset`=0, `sys_rst_n`=0, `fault`=1.
    - Sticky; a recovered lock is ignored.
    - `relock_req` clears `retry_cnt` and goes to RESET_PLL.
- `relock_req` is ignored in RESET_PLL, WAIT_LOCK and STABILIZE.
- Asserting `rst_n` mid-operation forces reset values immediately, regardless of state.

## Timing
- Reset values: state RESET_PLL, `cnt`=0, `pll_reset`=1, `sys_rst_n`=0, `locked`=0, `fault`=0, `retry_cnt`=0, synchronizer flops=0.
- All outputs are registered and decoded from the state register. An output changes on the clock edge that enters the new state.
- `pll_reset` stays high for exactly PLL_RST_CYCLES cycles per attempt, counted from the first edge with `rst_n` high.
- Rising `pll_lock` to STABILIZE takes 3 edges: 2 for the synchronizer, 1 for the FSM.
- Minimum rising `pll_lock` to `sys_rst_n`=1 is 2 + LOCK_STABLE_CYCLES + 1 edges.
- Falling `pll_lock` in RUN to `sys_rst_n`=0 takes 2 + LOSS_FILTER edges.
- `relock_req` to `pll_reset`=1 takes 1 edge.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOSS_FILTER=3, RETRY_TIMEOUT=20, MAX_RETRIES=2.
- Normal bring-up:
  - Stimulus: release `rst_n`; `pll_lock` rises 10 cycles after `pll_reset` falls.
  - Required: `pll_reset` high for exactly 4 cycles; `sys_rst_n` and `locked` rise 11 edges after `pll_lock` rises; `retry_cnt`=0.
- Lock glitch in STABILIZE:
  - Stimulus: `pll_lock` high for 5 cycles, low for 2, then high.
  - Required: return to WAIT_LOCK; release comes 11 edges after the second rise; `retry_cnt` unchanged.
- Loss filter:
  - Stimulus in RUN: `pll_lock` low for 2 cycles, then low for 3.
  - Required: the 2-cycle dip leaves `sys_rst_n`=1. The 3-cycle dip drives `sys_rst_n`=0 and `pll_reset`=1 5 edges after the fall, with `pll_reset` held for 4 cycles.
- Timeout and fault:
  - Stimulus: `pll_lock` held low.
  - Required: after the 1st 20-cycle WAIT_LOCK, `retry_cnt`=1 and a second 4-cycle `pll_reset` pulse. After the 2nd timeout, `retry_cnt`=2, `fault`=1, `pll_reset`=0. Raising `pll_lock` afterwards leaves `fault`=1.
- Relock request:
  - Stimulus: `relock_req` pulse in FAULT, then in RUN, then in STABILIZE.
  - Required: from FAULT, `retry_cnt`→0 and `pll_reset`=1 the next edge. From RUN, `sys_rst_n`=0 and `pll_reset`=1 the next edge. In STABILIZE, no effect.
- Reset mid-operation:
  - Stimulus: assert `rst_n` asynchronously in RUN.
  - Required: without waiting for a clock edge, `sys_rst_n`=0, `pll_reset`=1, `locked`=0, `retry_cnt`=0; the full bring-up sequence repeats after release.
